// File: rtl/instr_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: FSM state encoding,
// the default NOP word and the MIPS opcode constants also used by the decoder.
package instr_mem_loadable_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } imem_state_e;

   // sll r0,r0,0 encodes as all zeros
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic [5:0] opcode_of(input logic [31:0] word);
      return word[31:26];
   endfunction

endpackage

// File: rtl/instr_mem_loadable_ram.sv
// DEPTH x DATA_W storage with synchronous write and registered synchronous read.
module imem_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it maps onto block RAM; only the read register is reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: streams a program in over valid/ready, then serves
// PC fetches with a 1-cycle registered read, faulting misaligned or unloaded addresses.
module instr_mem_loadable
   import instr_mem_loadable_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 4,
   parameter int                PC_W     = ADDR_W + 2,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_done,
   input  logic              fetch_req,
   input  logic [PC_W-1:0]   fetch_addr,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              fetch_fault,
   output logic              busy,
   output logic [ADDR_W:0]   loaded_count
);

   localparam int              DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);

   imem_state_e state_q, state_d;

   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W:0]   loaded_count_q;
   logic              load_done_q;
   logic              fetch_valid_q;
   logic              fetch_fault_q;
   logic              nop_sel_q;

   logic              load_accept;
   logic              load_exit;
   logic              fetch_accept;
   logic              fetch_bad;
   logic [PC_W-3:0]   fetch_word;
   logic [DATA_W-1:0] ram_rdata;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      busy         = (state_q == ST_LOAD);
      // A restart pulse drops any word offered in the same cycle, so ready is withheld.
      load_ready   = busy && !load_start;
      load_accept  = load_valid && load_ready;
      load_exit    = load_accept && (load_last || (wr_ptr_q == LAST_PTR));

      unique case (state_q)
         ST_IDLE, ST_RUN: if (load_start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (load_start) begin
               state_d = ST_LOAD;
            end else if (load_exit) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Load and fetch never overlap, so the RAM needs no read/write collision handling.
      fetch_accept = fetch_req && (state_q != ST_LOAD) && !load_start;
      fetch_word   = fetch_addr[PC_W-1:2];
      fetch_bad    = (fetch_addr[1:0] != 2'b00) ||
                     (int'(fetch_word) >= int'(loaded_count_q));
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         wr_ptr_q       <= '0;
         loaded_count_q <= '0;
         load_done_q    <= 1'b0;
         fetch_valid_q  <= 1'b0;
         fetch_fault_q  <= 1'b0;
         nop_sel_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_done_q <= load_exit;

         if (load_start) begin
            wr_ptr_q       <= '0;
            loaded_count_q <= '0;
         end else if (load_accept) begin
            if (wr_ptr_q != LAST_PTR) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (loaded_count_q != FULL_CNT) loaded_count_q <= loaded_count_q + 1'b1;
         end

         fetch_valid_q <= fetch_accept;
         fetch_fault_q <= fetch_accept && fetch_bad;
         // Output select is sticky so instruction holds its last value between fetches.
         if (fetch_accept) nop_sel_q <= fetch_bad;
      end
   end

   imem_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (load_accept),
      .waddr (wr_ptr_q),
      .wdata (load_data),
      .re    (fetch_accept && !fetch_bad),
      .raddr (fetch_word[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   assign load_done    = load_done_q;
   assign fetch_valid  = fetch_valid_q;
   assign fetch_fault  = fetch_fault_q;
   assign instruction  = nop_sel_q ? NOP_WORD : ram_rdata;
   assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed + randomized bench for instr_mem_loadable against an array/count reference model.
module tb_instr_mem_loadable;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start, load_valid, load_last, load_ready, load_done;
   logic [31:0] load_data;
   logic        fetch_req, fetch_valid, fetch_fault, busy;
   logic [5:0]  fetch_addr;
   logic [31:0] instruction;
   logic [4:0]  loaded_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] model_mem [DEPTH];
   int          model_count = 0;
   logic [31:0] last_instr = 32'h0;

   always #5 clk = ~clk;

   instr_mem_loadable dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_done    (load_done),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_valid  (fetch_valid),
      .instruction  (instruction),
      .fetch_fault  (fetch_fault),
      .busy         (busy),
      .loaded_count (loaded_count)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one fetch (req left asserted for back-to-back use) and check the result next cycle.
   task automatic do_fetch(input logic [5:0] addr, input string tag);
      bit          exp_fault;
      logic [31:0] exp_instr;
      fetch_req  = 1'b1;
      fetch_addr = addr;
      exp_fault  = (addr % 4 != 0) || (int'(addr) / 4 >= model_count);
      exp_instr  = exp_fault ? 32'h0000_0000 : model_mem[int'(addr) / 4];
      step();
      check({tag, ".valid"}, 32'(fetch_valid), 32'd1);
      check({tag, ".fault"}, 32'(fetch_fault), 32'(exp_fault));
      check({tag, ".instr"}, instruction, exp_instr);
      last_instr = exp_instr;
   endtask

   // Load a program of n words, last flagged on the final one; assumes n <= DEPTH.
   task automatic load_words(input int n, input string tag);
      logic [31:0] w;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      model_count = 0;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         load_valid = 1'b1;
         load_data  = w;
         load_last  = (i == n - 1);
         #1;
         check({tag, ".ready"}, 32'(load_ready), 32'd1);
         step();
         model_mem[i] = w;
         model_count++;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check({tag, ".done"}, 32'(load_done), 32'd1);
      check({tag, ".count"}, 32'(loaded_count), 32'(n));
   endtask

   initial begin
      int          acc;
      int          done_cnt;
      logic [31:0] prog [3];
      prog[0] = 32'h8C01_0000;
      prog[1] = 32'h8C02_0004;
      prog[2] = 32'h1020_0001;

      rst = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_data = 32'h0; fetch_req = 1'b0; fetch_addr = 6'h0;
      step(); step();

      // Reset state
      check("rst.load_ready", 32'(load_ready), 32'd0);
      check("rst.load_done", 32'(load_done), 32'd0);
      check("rst.fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst.instruction", instruction, 32'h0);
      check("rst.fetch_fault", 32'(fetch_fault), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.loaded_count", 32'(loaded_count), 32'd0);
      rst = 1'b1;
      step();

      // Fetch with nothing loaded always faults
      do_fetch(6'd0, "idle_fetch");
      fetch_req = 1'b0;

      // Directed 3-word program
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check("prog.busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 2);
         #1;
         check("prog.ready", 32'(load_ready), 32'd1);
         step();
         model_mem[i] = prog[i];
      end
      model_count = 3;
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("prog.done", 32'(load_done), 32'd1);
      check("prog.count", 32'(loaded_count), 32'd3);
      check("prog.busy_off", 32'(busy), 32'd0);
      step();
      check("prog.done_pulse", 32'(load_done), 32'd0);

      do_fetch(6'd0, "prog_f0");
      do_fetch(6'd4, "prog_f4");
      do_fetch(6'd8, "prog_f8");
      do_fetch(6'd12, "prog_f12");
      do_fetch(6'd6, "misaligned");
      fetch_req = 1'b0;
      step();
      check("nofetch.valid", 32'(fetch_valid), 32'd0);
      check("nofetch.fault", 32'(fetch_fault), 32'd0);
      check("nofetch.hold", instruction, last_instr);

      for (int i = 0; i < 12; i++) do_fetch(6'($urandom_range(0, 63)), "rand3");
      fetch_req = 1'b0;

      // Overflow: 20 words, no last; only DEPTH accepted
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      acc = 0;
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         load_last  = 1'b0;
         #1;
         check("ovf.ready", 32'(load_ready), 32'(acc < DEPTH));
         if (acc < DEPTH) begin
            model_mem[acc] = load_data;
            acc++;
         end
         step();
         if (load_done) done_cnt++;
      end
      load_valid = 1'b0;
      step();
      if (load_done) done_cnt++;
      model_count = DEPTH;
      check("ovf.done_once", 32'(done_cnt), 32'd1);
      check("ovf.count", 32'(loaded_count), 32'(DEPTH));
      check("ovf.busy", 32'(busy), 32'd0);
      for (int i = 0; i < DEPTH; i++) do_fetch(6'(i * 4), "ovf_seq");
      for (int i = 0; i < 10; i++) do_fetch(6'($urandom_range(0, 63)), "ovf_rand");
      fetch_req = 1'b0;

      // Reset in the middle of a load
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         model_mem[i] = load_data;
         step();
      end
      load_valid = 1'b0;
      rst = 1'b0;
      #1;
      model_count = 0;
      check("midrst.count", 32'(loaded_count), 32'd0);
      check("midrst.busy", 32'(busy), 32'd0);
      check("midrst.ready", 32'(load_ready), 32'd0);
      step();
      rst = 1'b1;
      step();
      do_fetch(6'd0, "midrst_f0");
      fetch_req = 1'b0;

      // Get into RUN, then confirm stray load words are ignored there
      load_words(4, "run4");
      load_valid = 1'b1;
      load_data  = 32'hFFFF_FFFF;
      #1;
      check("run.ready", 32'(load_ready), 32'd0);
      step();
      load_valid = 1'b0;
      check("run.count_kept", 32'(loaded_count), 32'd4);
      do_fetch(6'd12, "run_f12");
      fetch_req = 1'b0;

      // Reload from RUN with a simultaneous fetch: load wins
      load_start = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 6'd0;
      step();
      check("reload.busy", 32'(busy), 32'd1);
      check("reload.fetch_drop", 32'(fetch_valid), 32'd0);
      check("reload.count", 32'(loaded_count), 32'd0);
      // Restart inside LOAD with a word offered: word dropped, fetch still dropped
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      #1;
      check("restart.ready", 32'(load_ready), 32'd0);
      step();
      check("load.fetch_drop", 32'(fetch_valid), 32'd0);
      check("restart.count", 32'(loaded_count), 32'd0);
      fetch_req  = 1'b0;
      load_start = 1'b0;
      load_data  = 32'h0022_1820;
      load_last  = 1'b1;
      #1;
      check("reload.ready", 32'(load_ready), 32'd1);
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      model_mem[0] = 32'h0022_1820;
      model_count  = 1;
      check("reload.done", 32'(load_done), 32'd1);
      check("reload.count1", 32'(loaded_count), 32'd1);
      do_fetch(6'd0, "reload_f0");
      do_fetch(6'd4, "reload_f4");
      fetch_req = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
